// File: rtl/gpio_sync_filter_if.sv
// Pin-side bundle for gpio_sync_filter: raw pads and controls in, synchronized,
// filtered and edge/flag results out.
interface gpio_sync_filter_if #(
  parameter int p_width = 8
);
  logic [p_width-1:0] d_in;
  logic [p_width-1:0] filt_en;
  logic [p_width-1:0] pc_clr;
  logic [p_width-1:0] d_sync;
  logic [p_width-1:0] d_filt;
  logic [p_width-1:0] rise;
  logic [p_width-1:0] fall;
  logic [p_width-1:0] pc_flag;

  modport master (
    output d_in, filt_en, pc_clr,
    input  d_sync, d_filt, rise, fall, pc_flag
  );

  modport slave (
    input  d_in, filt_en, pc_clr,
    output d_sync, d_filt, rise, fall, pc_flag
  );
endinterface

// File: rtl/gpio_sync_filter.sv
// Multi-stage pad synchronizer with per-bit glitch filter, edge pulses and
// sticky pin-change flags. Every bit is independent.
module gpio_sync_filter #(
  parameter int p_width    = 8,
  parameter int p_stages   = 2,
  parameter int p_filt_cnt = 3,
  parameter int p_cnt_w    = $clog2(p_filt_cnt + 1)
) (
  input logic                clk,
  input logic                rst,
  gpio_sync_filter_if.slave  io_bus
);

  if (p_stages < 2) begin : g_bad_stages
    $error("gpio_sync_filter: p_stages must be 2 or more");
  end
  if (p_filt_cnt < 1) begin : g_bad_filt
    $error("gpio_sync_filter: p_filt_cnt must be 1 or more");
  end

  logic [p_width-1:0] r_sync [p_stages];
  logic [p_width-1:0] r_filt;
  logic [p_width-1:0] r_prev;
  logic [p_width-1:0] r_flag;
  logic [p_cnt_w-1:0] r_cnt [p_width];

  logic [p_width-1:0] w_sync;
  logic [p_width-1:0] w_rise;
  logic [p_width-1:0] w_fall;

  assign w_sync = r_sync[p_stages-1];
  assign w_rise = r_filt & ~r_prev;
  assign w_fall = ~r_filt & r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < p_stages; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= io_bus.d_in;
      for (int unsigned s = 1; s < p_stages; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  // The edge that would bring the count to p_filt_cnt updates d_filt and
  // clears the counter instead, so the counter stays below p_filt_cnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_filt <= '0;
      r_prev <= '0;
      r_flag <= '0;
      for (int unsigned b = 0; b < p_width; b++) r_cnt[b] <= '0;
    end else begin
      r_prev <= r_filt;
      r_flag <= (r_flag & ~io_bus.pc_clr) | w_rise | w_fall;
      for (int unsigned b = 0; b < p_width; b++) begin
        if (!io_bus.filt_en[b]) begin
          r_filt[b] <= w_sync[b];
          r_cnt[b]  <= '0;
        end else if (w_sync[b] == r_filt[b]) begin
          r_cnt[b] <= '0;
        end else if (r_cnt[b] == p_cnt_w'(p_filt_cnt - 1)) begin
          r_filt[b] <= w_sync[b];
          r_cnt[b]  <= '0;
        end else begin
          r_cnt[b] <= r_cnt[b] + 1'b1;
        end
      end
    end
  end

  assign io_bus.d_sync  = w_sync;
  assign io_bus.d_filt  = r_filt;
  assign io_bus.rise    = w_rise;
  assign io_bus.fall    = w_fall;
  assign io_bus.pc_flag = r_flag;

endmodule

// File: tb/tb_gpio_sync_filter.sv
// Bench for gpio_sync_filter: a p_filt_cnt=3 instance and a p_filt_cnt=1
// instance driven in parallel and compared against a history-based model.
module tb_gpio_sync_filter;

  localparam int P_STAGES = 2;
  localparam int P_FILT   = 3;
  localparam int HMAX     = 4096;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d_in;
  logic [7:0] filt_en;
  logic [7:0] pc_clr;

  int checks   = 0;
  int failures = 0;

  gpio_sync_filter_if #(.p_width(8)) bus1 ();
  gpio_sync_filter_if #(.p_width(8)) bus2 ();

  assign bus1.d_in    = d_in;
  assign bus1.filt_en = filt_en;
  assign bus1.pc_clr  = pc_clr;
  assign bus2.d_in    = d_in;
  assign bus2.filt_en = filt_en;
  assign bus2.pc_clr  = pc_clr;

  gpio_sync_filter #(.p_width(8), .p_stages(P_STAGES), .p_filt_cnt(P_FILT)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus1.slave)
  );

  gpio_sync_filter #(.p_width(8), .p_stages(P_STAGES), .p_filt_cnt(1)) u_dut_n1 (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus2.slave)
  );

  always #5 clk = ~clk;

  // Per-edge histories: value of each quantity right after edge t.
  logic [7:0] din_h  [HMAX];
  logic [7:0] en_h   [HMAX];
  logic [7:0] seen_h [HMAX];
  logic [7:0] sync_h [HMAX];
  logic [7:0] filt_h [HMAX];
  logic [7:0] f2_h   [HMAX];
  int         last_flip [8];
  int         t        = 0;
  int         rst_mark = 0;
  logic [7:0] m_flag   = '0;
  logic [7:0] m2_flag  = '0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic zero_hist(input int i);
    din_h[i] = '0; en_h[i] = '0; seen_h[i] = '0;
    sync_h[i] = '0; filt_h[i] = '0; f2_h[i] = '0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    chk("async_rst_zero", bus1.d_sync | bus1.d_filt | bus1.rise | bus1.fall | bus1.pc_flag |
        bus2.d_sync | bus2.d_filt | bus2.rise | bus2.fall | bus2.pc_flag, 8'h00);
    repeat (n) begin
      @(posedge clk);
      t++;
      zero_hist(t);
    end
    #1;
    rst      = 1'b0;
    rst_mark = t;
    m_flag   = '0;
    m2_flag  = '0;
    for (int b = 0; b < 8; b++) last_flip[b] = t;
  endtask

  // One clock: apply inputs, advance the model from the recorded history,
  // then compare both instances shortly after the edge.
  task automatic step(input logic [7:0] di, input logic [7:0] en_i, input logic [7:0] clr_i);
    logic [7:0] seen;
    logic [7:0] nf;
    bit         q;
    d_in    = di;
    filt_en = en_i;
    pc_clr  = clr_i;
    @(posedge clk);
    t++;
    din_h[t]  = di;
    en_h[t]   = en_i;
    seen      = sync_h[t-1];
    seen_h[t] = seen;
    sync_h[t] = (t - (P_STAGES - 1) > rst_mark) ? din_h[t-(P_STAGES-1)] : 8'h00;
    nf = filt_h[t-1];
    for (int b = 0; b < 8; b++) begin
      if (!en_i[b]) begin
        nf[b] = seen[b];
      end else begin
        q = 1'b1;
        for (int j = 0; j < P_FILT; j++) begin
          int e;
          e = t - j;
          if (e <= last_flip[b] || !en_h[e][b] || seen_h[e][b] == filt_h[t-1][b]) q = 1'b0;
        end
        if (q) nf[b] = ~filt_h[t-1][b];
      end
      if (nf[b] != filt_h[t-1][b]) last_flip[b] = t;
    end
    filt_h[t] = nf;
    m_flag    = (m_flag & ~clr_i) | (filt_h[t-1] ^ filt_h[t-2]);
    f2_h[t]   = seen;
    m2_flag   = (m2_flag & ~clr_i) | (f2_h[t-1] ^ f2_h[t-2]);
    #1;
    chk("d_sync",     bus1.d_sync,  sync_h[t]);
    chk("d_filt",     bus1.d_filt,  filt_h[t]);
    chk("rise",       bus1.rise,    filt_h[t] & ~filt_h[t-1]);
    chk("fall",       bus1.fall,    ~filt_h[t] & filt_h[t-1]);
    chk("pc_flag",    bus1.pc_flag, m_flag);
    chk("n1_d_sync",  bus2.d_sync,  sync_h[t]);
    chk("n1_d_filt",  bus2.d_filt,  f2_h[t]);
    chk("n1_rise",    bus2.rise,    f2_h[t] & ~f2_h[t-1]);
    chk("n1_fall",    bus2.fall,    ~f2_h[t] & f2_h[t-1]);
    chk("n1_pc_flag", bus2.pc_flag, m2_flag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rin;
    logic [7:0] ren;
    d_in    = 8'hFF;
    filt_en = 8'h00;
    pc_clr  = 8'h00;
    for (int i = 0; i < 3; i++) zero_hist(i);
    do_reset(3);

    // reset release with pads high, unfiltered
    step(8'hFF, 8'h00, 8'h00);
    step(8'hFF, 8'h00, 8'h00);
    chk("rel_dsync", bus1.d_sync, 8'hFF);
    chk("rel_norise", bus1.rise, 8'h00);
    step(8'hFF, 8'h00, 8'h00);
    chk("rel_dfilt", bus1.d_filt, 8'hFF);
    chk("rel_rise", bus1.rise, 8'hFF);
    step(8'hFF, 8'h00, 8'h00);
    chk("rel_rise_end", bus1.rise, 8'h00);
    chk("rel_flag", bus1.pc_flag, 8'hFF);

    repeat (4) step(8'h00, 8'h00, 8'h00);
    repeat (2) step(8'h00, 8'h00, 8'hFF);

    // unfiltered latency on bit 3
    step(8'h08, 8'h00, 8'h00);
    step(8'h08, 8'h00, 8'h00);
    chk("unf_dsync", bus1.d_sync, 8'h08);
    chk("unf_dfilt_early", bus1.d_filt, 8'h00);
    step(8'h08, 8'h00, 8'h00);
    chk("unf_dfilt", bus1.d_filt, 8'h08);
    chk("unf_rise", bus1.rise, 8'h08);
    step(8'h08, 8'h00, 8'h00);
    chk("unf_rise_end", bus1.rise, 8'h00);
    chk("unf_flag", bus1.pc_flag, 8'h08);

    // 2-cycle glitch on bit 0 is rejected
    repeat (2) step(8'h09, 8'hFF, 8'h00);
    repeat (6) step(8'h08, 8'hFF, 8'h00);
    chk("glitch_dfilt", bus1.d_filt, 8'h08);
    chk("glitch_flag", bus1.pc_flag, 8'h08);

    // 3-cycle pulse on bit 0 passes
    for (int i = 0; i < 10; i++) begin
      step((i < 3) ? 8'h09 : 8'h08, 8'hFF, 8'h00);
      if (i == 3) chk("pulse_not_yet", bus1.d_filt, 8'h08);
      if (i == 4) chk("pulse_rise", bus1.rise, 8'h01);
      if (i == 7) chk("pulse_fall", bus1.fall, 8'h01);
    end

    // filtered latency 00 -> A5
    repeat (8) step(8'h00, 8'hFF, 8'h00);
    step(8'h00, 8'hFF, 8'hFF);
    step(8'h00, 8'hFF, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(8'hA5, 8'hFF, 8'h00);
      if (i == 2) chk("n1_filt_lat", bus2.rise, 8'hA5);
      if (i == 3) chk("filt_lat_early", bus1.d_filt, 8'h00);
      if (i == 4) chk("filt_lat_rise", bus1.rise, 8'hA5);
    end
    step(8'hA5, 8'hFF, 8'h00);

    // set/clear race on bit 5
    for (int i = 0; i < 5; i++) step(8'h85, 8'hFF, 8'h00);
    chk("race_fall", bus1.fall, 8'h20);
    step(8'h85, 8'hFF, 8'h20);
    chk("race_set_wins", bus1.pc_flag & 8'h20, 8'h20);
    step(8'h85, 8'hFF, 8'h20);
    chk("race_clear", bus1.pc_flag & 8'h20, 8'h00);

    // filt_en[2] dropped mid-count
    repeat (3) step(8'h81, 8'hFF, 8'h00);
    chk("en_drop_before", bus1.d_filt & 8'h04, 8'h04);
    step(8'h81, 8'hFB, 8'h00);
    chk("en_drop_follow", bus1.d_filt & 8'h04, 8'h00);

    // reset during a count
    step(8'h81, 8'hFF, 8'h00);
    repeat (3) step(8'hFF, 8'hFF, 8'h00);
    do_reset(2);
    step(8'hFF, 8'hFF, 8'h00);
    chk("post_rst_nopulse", bus1.rise | bus1.fall, 8'h00);

    // randomized traffic
    rin = 8'hFF;
    ren = 8'hFF;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset(2);
      rin = rin ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 15) == 0) ren = 8'($urandom);
      step(rin, ren, 8'($urandom) & 8'($urandom) & 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_sync_filter.md
Name: gpio_sync_filter

Overview:
- Parametrised successor to the plain pin synchronizer. It feeds the GPIO PINx read path and the pin-change interrupt logic.
- Brings p_width asynchronous pad inputs into the clk domain through a configurable flop chain.
- Applies an optional per-bit digital glitch filter.
- Produces single-cycle rise/fall pulses and sticky pin-change flags with per-bit clear.

Parameters:
- p_width, 8, number of pin bits.
- p_stages, 2, synchronizer flop depth. Legal range is 2 or more; elaboration error below 2.
- p_filt_cnt, 3, consecutive mismatching samples needed before d_filt changes. Legal range is 1 or more; 1 behaves as unfiltered.
- p_cnt_w, $clog2(p_filt_cnt+1), filter counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- d_in  input  p_width  raw asynchronous pad inputs.
- filt_en  input  p_width  per-bit filter enable (synchronous to clk).
- pc_clr  input  p_width  per-bit clear of pc_flag (synchronous, level).
- d_sync  output  p_width  last stage of the synchronizer chain.
- d_filt  output  p_width  filtered, registered pin value.
- rise  output  p_width  one-cycle pulse on a 0->1 change of d_filt.
- fall  output  p_width  one-cycle pulse on a 1->0 change of d_filt.
- pc_flag  output  p_width  sticky pin-change flag.

Behaviour:
- Reset: rst high clears all sync stages, filter counters, d_filt, the d_filt history register and pc_flag to 0, immediately and asynchronously. Outputs therefore reset as follows: d_sync=0, d_filt=0, rise=0, fall=0, pc_flag=0. Release of rst takes effect at the next clk edge; no edge pulse is generated on reset release.
- Sync chain: p_stages flops per bit, all flip-flops (no latches). A d_in change set up before edge N appears on d_sync after edge N+p_stages-1.
- Filter per bit, with filt_en=0:
  - d_filt <= d_sync every edge.
  - The counter is held at 0.
  - Latency from d_in is p_stages edges.
- Filter per bit, with filt_en=1:
  - If d_sync == d_filt, the counter goes to 0.
  - Otherwise the counter increments.
  - When the counter would reach p_filt_cnt, d_filt <= d_sync and the counter goes to 0 on that same edge.
  - A change on d_sync therefore reaches d_filt on the p_filt_cnt-th consecutive mismatching edge.
  - Latency from d_in is p_stages+p_filt_cnt-1 edges.
  - Pulses shorter than p_filt_cnt cycles on d_sync never reach d_filt.
- Counter width: p_cnt_w. The counter never exceeds p_filt_cnt, so no wrap is possible.
- filt_en toggling mid-count: on the 1->0 transition the counter clears and d_filt follows d_sync from that edge. On 0->1 counting starts from 0.
- Edge detect: an internal register d_prev <= d_filt every edge.
  - rise = d_filt & ~d_prev.
  - fall = ~d_filt & d_prev.
  - Both are driven only from registers, so they are glitch-free.
  - Each pulse is exactly 1 cycle, asserted in the cycle d_filt first shows its new value.
- pc_flag per bit:
  - Set on the edge after rise|fall is high.
  - Cleared on an edge where pc_clr=1.
  - Set and clear in the same cycle: set wins, and the flag stays 1.
  - Held otherwise.
- Bits are fully independent; there is no cross-bit interaction.
- Reset asserted mid-filter: the count is abandoned, and after release the bit re-qualifies from d_filt=0.

Test Plan (p_width=8, p_stages=2, p_filt_cnt=3 unless noted):
- Reset: hold rst with d_in=8'hFF -> all outputs 0. Release rst -> d_sync=8'hFF after 2 edges and no rise pulse before d_filt changes. filt_en=0 gives d_filt=8'hFF at edge 3 with rise=8'hFF for exactly 1 cycle.
- Unfiltered latency: filt_en=0, d_in[3] 0->1 before edge k -> d_sync[3]=1 after edge k+1, d_filt[3]=1 and rise[3]=1 after edge k+2, rise[3]=0 after edge k+3, pc_flag[3]=1 after edge k+3.
- Glitch rejection: filt_en=8'hFF, d_in[0] high for 2 cycles then low -> d_filt[0] stays 0, rise/fall stay 0, pc_flag stays 0. A 3-cycle high pulse -> d_filt[0] goes 1 for 3 cycles, with a rise pulse then a fall pulse.
- Filtered latency: filt_en=8'hFF, d_in 8'h00->8'hA5 held -> d_filt=8'hA5 on the 4th edge after d_in changes, with rise=8'hA5 for 1 cycle. Repeat with p_filt_cnt=1 -> behaves identically to filt_en=0.
- Flag set/clear race: pc_flag[5]=1, then pc_clr[5]=1 in the same cycle a new fall[5] pulse is high -> pc_flag[5] remains 1. With pc_clr[5]=1 alone -> pc_flag[5]=0 next edge.
- Mid-operation events: filt_en[2] 1->0 after 2 mismatching edges -> d_filt[2] updates on the next edge. Asserting rst during a count -> immediate 0 outputs and no pulse after release.
